imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: serial program loader for the instruction memory.
// Receives an 8N1 UART stream framed as A5, N, then 4*N little-endian data
// bytes, and writes N words to imem starting at byte address 0. The CPU
// core is held in reset for the duration of a load.
module imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  // One extra bit so a length equal to the full capacity is representable.
  localparam int LW = ADDR_WIDTH - 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   CAPACITY  = 32'(1) << (ADDR_WIDTH - 2);
  localparam logic [7:0]    HEADER    = 8'hA5;

  // ---------------------------------------------------------------- UART RX
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  logic            rxd_meta_reg;
  logic            rxd_sync_reg;
  rx_state_t       rx_state_reg;
  logic [TW-1:0]   rx_timer_reg;
  logic [2:0]      rx_bit_reg;
  logic [7:0]      rx_shift_reg;
  logic            byte_valid_reg;
  logic            frame_err_reg;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_sync_reg <= rxd_meta_reg;
    end
  end

  // Bit-timed receiver: start-bit check at mid bit, LSB-first data, one stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg   <= RX_IDLE;
      rx_timer_reg   <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          // Idle is only entered with the line high, so a low level here is a falling edge.
          if (!rxd_sync_reg) begin
            rx_state_reg <= RX_START;
            rx_timer_reg <= '0;
          end
        end
        RX_START: begin
          if (rx_timer_reg == HALF_LAST) begin
            rx_timer_reg <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rxd_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_timer_reg <= rx_timer_reg + TW'(1);
          end
        end
        RX_DATA: begin
          if (rx_timer_reg == BIT_LAST) begin
            rx_timer_reg <= '0;
            rx_shift_reg <= {rxd_sync_reg, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) begin
              rx_state_reg <= RX_STOP;
            end else begin
              rx_bit_reg <= rx_bit_reg + 3'd1;
            end
          end else begin
            rx_timer_reg <= rx_timer_reg + TW'(1);
          end
        end
        RX_STOP: begin
          if (rx_timer_reg == BIT_LAST) begin
            rx_timer_reg <= '0;
            if (rxd_sync_reg) begin
              byte_valid_reg <= 1'b1;
              rx_state_reg   <= RX_IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              rx_state_reg  <= RX_WAIT_HIGH;
            end
          end else begin
            rx_timer_reg <= rx_timer_reg + TW'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rxd_sync_reg) begin
            rx_state_reg <= RX_IDLE;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- loader
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN,
    LD_DATA,
    LD_WRITE,
    LD_FIN
  } ld_state_t;

  ld_state_t             ld_state_reg;
  logic [LW-1:0]         len_reg;
  logic [LW-1:0]         word_idx_reg;
  logic [1:0]            byte_cnt_reg;
  logic [31:0]           asm_word;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [31:0]           wdata_reg;
  logic                  cpu_rst_reg;
  logic                  done_reg;
  logic                  err_reg;

  // Word assembly: one byte lane per position, loaded when byte_cnt selects it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_reg;

    // Capture the received byte into this lane while collecting data.
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_reg <= '0;
      end else if (ld_state_reg == LD_DATA && byte_valid_reg && byte_cnt_reg == 2'(gi)) begin
        lane_reg <= rx_shift_reg;
      end
    end

    assign asm_word[gi*8 +: 8] = lane_reg;
  end

  // Frame parser and imem write sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_reg <= LD_IDLE;
      len_reg      <= '0;
      word_idx_reg <= '0;
      byte_cnt_reg <= '0;
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      cpu_rst_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      we_reg      <= 1'b0;
      done_reg    <= 1'b0;
      cpu_rst_reg <= (ld_state_reg != LD_IDLE);
      if (frame_err_reg) begin
        // A corrupted byte makes the rest of the frame untrustworthy.
        err_reg      <= 1'b1;
        ld_state_reg <= LD_IDLE;
      end else begin
        case (ld_state_reg)
          LD_IDLE: begin
            if (byte_valid_reg && rx_shift_reg == HEADER) begin
              err_reg      <= 1'b0;
              ld_state_reg <= LD_LEN;
            end
          end
          LD_LEN: begin
            if (byte_valid_reg) begin
              if (rx_shift_reg == 8'd0) begin
                ld_state_reg <= LD_IDLE;
              end else if ({24'd0, rx_shift_reg} > CAPACITY) begin
                err_reg      <= 1'b1;
                ld_state_reg <= LD_IDLE;
              end else begin
                len_reg      <= LW'(rx_shift_reg);
                word_idx_reg <= '0;
                byte_cnt_reg <= '0;
                ld_state_reg <= LD_DATA;
              end
            end
          end
          LD_DATA: begin
            if (byte_valid_reg) begin
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
              if (byte_cnt_reg == 2'd3) begin
                ld_state_reg <= LD_WRITE;
              end
            end
          end
          LD_WRITE: begin
            we_reg       <= 1'b1;
            waddr_reg    <= {word_idx_reg[ADDR_WIDTH-3:0], 2'b00};
            wdata_reg    <= asm_word;
            word_idx_reg <= word_idx_reg + LW'(1);
            byte_cnt_reg <= '0;
            if ((word_idx_reg + LW'(1)) == len_reg) begin
              ld_state_reg <= LD_FIN;
            end else begin
              ld_state_reg <= LD_DATA;
            end
          end
          LD_FIN: begin
            done_reg     <= 1'b1;
            ld_state_reg <= LD_IDLE;
          end
          default: ld_state_reg <= LD_IDLE;
        endcase
      end
    end
  end

  assign we      = we_reg;
  assign waddr   = waddr_reg;
  assign wdata   = wdata_reg;
  assign cpu_rst = cpu_rst_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives framed UART bytes, a scoreboard monitor
// checks every imem write and every done pulse as the DUT presents them.
module tb_imem_loader;

  localparam int CPB = 4;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .cpu_rst(cpu_rst),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cycle = 0;
  int  done_cnt = 0;
  int  exp_done = 0;
  int  last_we_cycle = -100;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on each write, checks done timing.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (we) begin
        last_we_cycle = cycle;
        if (exp_q.size() == 0) begin
          check("we_unexpected", 64'(we), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("waddr", 64'(waddr), 64'(mon_e.addr));
          check("wdata", 64'(wdata), 64'(mon_e.data));
          $display("write: waddr=0x%02h wdata=0x%08h (expected 0x%02h 0x%08h)",
                   waddr, wdata, mon_e.addr, mon_e.data);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_we", 64'(cycle), 64'(last_we_cycle + 1));
        check("cpu_rst_at_done", 64'(cpu_rst), 64'd1);
        $display("done pulse at cycle %0d", cycle);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(CPB);
    end
    rxd = stop;
    wait_cycles(CPB);
    rxd = 1'b1;
    wait_cycles(CPB);
    $display("tx byte 0x%02h stop=%0d", b, stop);
  endtask

  task automatic send_seq(input logic [7:0] bytes[], input int n);
    for (int i = 0; i < n; i++) send_byte(bytes[i], 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[];
    rst = 1'b1;
    rxd = 1'b1;
    wait_cycles(3);
    #1;
    check("reset_we",      64'(we),      64'd0);
    check("reset_waddr",   64'(waddr),   64'd0);
    check("reset_wdata",   64'(wdata),   64'd0);
    check("reset_cpu_rst", 64'(cpu_rst), 64'd0);
    check("reset_done",    64'(done),    64'd0);
    check("reset_err",     64'(err),     64'd0);
    @(posedge clk);
    rst = 1'b0;
    wait_cycles(4);

    // 1: two-word load
    expect_write(8'h00, 32'h0000_0013);
    expect_write(8'h04, 32'h0000_20B7);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    wait_cycles(2);
    check("t1_cpu_rst_loading", 64'(cpu_rst), 64'd1);
    seq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h20, 8'h00, 8'h00};
    send_seq(seq, 8);
    wait_cycles(10);
    exp_done = 1;
    check("t1_done_count", 64'(done_cnt), 64'(exp_done));
    check("t1_err",        64'(err),      64'd0);
    check("t1_cpu_rst",    64'(cpu_rst),  64'd0);

    // 2: leading junk ignored
    expect_write(8'h00, 32'hFE1F_F06F);
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h6F, 8'hF0, 8'h1F, 8'hFE};
    send_seq(seq, 8);
    wait_cycles(10);
    exp_done = 2;
    check("t2_done_count", 64'(done_cnt), 64'(exp_done));
    check("t2_err",        64'(err),      64'd0);
    check("t2_cpu_rst",    64'(cpu_rst),  64'd0);

    // 3: over-capacity, zero length, header byte as length
    seq = '{8'hA5, 8'h41};
    send_seq(seq, 2);
    wait_cycles(10);
    check("t3_err_overcap",  64'(err),     64'd1);
    check("t3_cpu_rst",      64'(cpu_rst), 64'd0);
    seq = '{8'hA5, 8'h00};
    send_seq(seq, 2);
    wait_cycles(10);
    check("t3_err_cleared",  64'(err),      64'd0);
    check("t3_done_count",   64'(done_cnt), 64'(exp_done));
    check("t3_cpu_rst_zero", 64'(cpu_rst),  64'd0);
    seq = '{8'hA5, 8'hA5};
    send_seq(seq, 2);
    wait_cycles(10);
    check("t3_err_len_a5",   64'(err),     64'd1);

    // 4: framing error mid-frame, then a clean frame
    seq = '{8'hA5, 8'h01, 8'hAA};
    send_seq(seq, 3);
    send_byte(8'h55, 1'b0);
    wait_cycles(10);
    check("t4_err_frame", 64'(err),     64'd1);
    check("t4_cpu_rst",   64'(cpu_rst), 64'd0);
    expect_write(8'h00, 32'h4433_2211);
    seq = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_seq(seq, 6);
    wait_cycles(10);
    exp_done = 3;
    check("t4_done_count", 64'(done_cnt), 64'(exp_done));
    check("t4_err",        64'(err),      64'd0);

    // 5: reset after the 2nd of 3 words; A5 inside data is plain data
    expect_write(8'h00, 32'h0100_A5A5);
    expect_write(8'h04, 32'h1234_5678);
    seq = '{8'hA5, 8'h03, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    send_seq(seq, 10);
    wait_cycles(10);
    check("t5_writes_seen",  64'(exp_q.size()), 64'd0);
    check("t5_cpu_rst_busy", 64'(cpu_rst),      64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_cpu_rst_after_rst", 64'(cpu_rst), 64'd0);
    check("t5_we_after_rst",      64'(we),      64'd0);
    rst = 1'b0;
    wait_cycles(60);
    check("t5_done_count_abort", 64'(done_cnt), 64'(exp_done));
    expect_write(8'h00, 32'hDEAD_BEEF);
    seq = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(seq, 6);
    wait_cycles(10);
    exp_done = 4;
    check("t5_done_count", 64'(done_cnt), 64'(exp_done));

    // 6: short low glitch on rxd
    @(posedge clk);
    rxd = 1'b0;
    @(posedge clk);
    rxd = 1'b1;
    wait_cycles(40);
    check("t6_err",        64'(err),      64'd0);
    check("t6_cpu_rst",    64'(cpu_rst),  64'd0);
    check("t6_done_count", 64'(done_cnt), 64'(exp_done));

    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
